data_mem_responder: RTL
=======================

// Module: data_mem_responder
// PURPOSE
//  Data-memory responder for the load/store handshake issued by memory_writeback.
//  Accepts one request at a time and performs byte-lane steering for stores.
//  Performs sign/zero extension for loads, per func3.
//  Answers each request with a one-cycle done pulse after a programmable wait-state count.
//  Sits beside the core; it replaces a zero-latency memory so that stall paths can be exercised.
// PARAMETERS
//  DEPTH_WORDS  1024       number of 32-bit words in the internal array
//  BASE_ADDR    32'h0      byte address of word 0; the decode window is BASE_ADDR .. BASE_ADDR+4*DEPTH_WORDS-1
//  LATENCY      1          cycles from request acceptance to done; legal range 1..15
//  MEM_INIT     ""         hex file for $readmemh; empty string = contents undefined
// PORTS
//  clk     in   1   clock; all state updates on the rising edge
//  rst     in   1   asynchronous, active-low reset
//  req     in   1   request valid; level, held by the requester until done
//  we      in   1   1 = store, 0 = load; sampled at acceptance
//  func3   in   3   RV32I width/sign code (LB/LH/LW/LBU/LHU, SB/SH/SW); sampled at acceptance
//  addr    in   32  byte address; sampled at acceptance
//  wdata   in   32  store data, right-aligned (byte in [7:0], half in [15:0]); sampled at acceptance
//  done    out  1   one-cycle pulse marking transaction completion
//  rdata   out  32  extended load data; valid when done=1, held until the next done
//  err     out  1   valid with done: misaligned, out-of-window, or illegal func3
// BEHAVIOUR
//  Reset (rst=0, asynchronous): FSM->IDLE, wait counter=0, done=0, rdata=0, err=0.
//   Array contents are not cleared.
//  FSM states: IDLE, WAIT, RESP.
//   IDLE: req=1 -> latch we/func3/addr/wdata, load counter with LATENCY-1, go to WAIT.
//         req=0 -> stay in IDLE.
//   WAIT: counter!=0 -> decrement and stay. counter==0 -> go to RESP; at this edge the store commits or the load word is read.
//   RESP: done=1, rdata/err registered from this edge. Next state is IDLE unconditionally.
//  Latency: request accepted at edge k -> done high in the cycle following edge k+LATENCY.
//  Handshake: the requester drops req, or presents a new request, in the cycle after done.
//   A req seen high in IDLE is always a new transaction; back-to-back requests cost 1 idle cycle.
//   req changes outside IDLE are ignored (the latched copy is used).
//  Alignment and lanes:
//   Word index = (addr-BASE_ADDR)>>2.
//   SB writes byte lane addr[1:0]. SH writes lanes {addr[1],0}+1:{addr[1],0}. SW writes all 4 lanes.
//   LB/LH sign-extend the selected lane(s); LBU/LHU zero-extend; LW returns the word unchanged.
//  Errors (err=1 with done, no array write, rdata=0):
//   - halfword access with addr[0]=1
//   - word access with addr[1:0]!=0
//   - addr outside the decode window
//   - func3 in {011,110,111}, or a store with func3[2]=1
//  Reset mid-operation:
//   - asserted in WAIT before the commit edge -> no write, no done.
//   - asserted in RESP -> done drops immediately (asynchronous); the write has already happened.
//  Simultaneous req and rst=0: reset wins; nothing is latched.
// STRUCTURE
//  Shared header param_mem.vh:
//   func3 codes `MEM_B/`MEM_H/`MEM_W/`MEM_BU/`MEM_HU.
//   FSM state encodings `MS_IDLE/`MS_WAIT/`MS_RESP.
//   `MEM_LAT_W (counter width = 4).
//  One sub-module, mem_lane_align, is purely combinational. It produces:
//   - byte-enable[3:0] and shifted write data from func3/addr[1:0]/wdata
//   - extended load data from func3/addr[1:0]/raw word
//   - the alignment error flag
//  The top level holds the FSM, request latches, counter, and a reg [31:0] array with per-byte write enables.
// TESTING
//  1. SW addr=0x10 wdata=0xDEADBEEF, LATENCY=1 -> done in the cycle after edge k+1, err=0.
//     Then LW 0x10 -> rdata=0xDEADBEEF.
//  2. SB 0x13 data=0x80, then LB 0x13 -> rdata=0xFFFFFF80; LBU 0x13 -> 0x00000080.
//     LW 0x10 -> 0x80ADBEEF.
//  3. SH 0x11 -> done with err=1, word 0x10 unchanged.
//     LW 0x4*DEPTH_WORDS -> err=1, rdata=0.
//  4. LATENCY=4: req held from acceptance at edge k -> done exactly once, in the cycle after edge k+4.
//     Requester changes addr during WAIT -> original addr is used.
//  5. SW 0x20 with rst pulled low in the second WAIT cycle (LATENCY=4) -> done never rises.
//     After reset, LW 0x20 returns the pre-store value.
//  6. Two back-to-back requests (req re-raised the cycle after done) -> two done pulses, one idle cycle apart.
//     Each request has the correct data.

Source files
------------

// File: rtl/data_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_responder_pkg
// Brief    : Shared func3 codes, FSM states and helpers for the data-memory
//            responder.
// Revision : 1.0 - initial release
// ============================================================================
package data_mem_responder_pkg;

  localparam logic [2:0] c_MEM_B  = 3'b000;
  localparam logic [2:0] c_MEM_H  = 3'b001;
  localparam logic [2:0] c_MEM_W  = 3'b010;
  localparam logic [2:0] c_MEM_BU = 3'b100;
  localparam logic [2:0] c_MEM_HU = 3'b101;

  localparam int MEM_LAT_W = 4;

  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_WAIT = 2'd1,
    MS_RESP = 2'd2
  } mem_state_t;

  // Unsigned widths have no store form, and 011/110/111 are unused in RV32I.
  function automatic logic func3_illegal(input logic is_store, input logic [2:0] f3);
    func3_illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) ||
                    (is_store && f3[2]);
  endfunction

endpackage
`default_nettype wire

// File: rtl/data_mem_responder_lane_align.sv
`default_nettype none
// ============================================================================
// Module   : mem_lane_align
// Brief    : Combinational byte-lane steering for stores, load extension and
//            alignment checking.
// Revision : 1.0 - initial release
// ============================================================================
module mem_lane_align
  import data_mem_responder_pkg::*;
(
  input  logic [2:0]  i_func3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_raw,
  output logic [3:0]  o_byte_en,
  output logic [31:0] o_wdata_sh,
  output logic [31:0] o_load_data,
  output logic        o_misaligned
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_raw[{i_addr_lo, 3'b000} +: 8];
  assign w_half = i_addr_lo[1] ? i_raw[31:16] : i_raw[15:0];

  always_comb begin
    o_byte_en    = 4'b0000;
    o_wdata_sh   = '0;
    o_load_data  = '0;
    o_misaligned = 1'b0;
    case (i_func3)
      c_MEM_B, c_MEM_BU: begin
        o_byte_en   = 4'b0001 << i_addr_lo;
        o_wdata_sh  = {4{i_wdata[7:0]}};
        o_load_data = (i_func3 == c_MEM_B) ? {{24{w_byte[7]}}, w_byte}
                                           : {24'b0, w_byte};
      end
      c_MEM_H, c_MEM_HU: begin
        o_misaligned = i_addr_lo[0];
        o_byte_en    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata_sh   = {2{i_wdata[15:0]}};
        o_load_data  = (i_func3 == c_MEM_H) ? {{16{w_half[15]}}, w_half}
                                            : {16'b0, w_half};
      end
      c_MEM_W: begin
        o_misaligned = |i_addr_lo;
        o_byte_en    = 4'b1111;
        o_wdata_sh   = i_wdata;
        o_load_data  = i_raw;
      end
      default: begin
        o_byte_en = 4'b0000;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_responder
// Brief    : Wait-state data memory answering load/store requests with a
//            one-cycle done pulse after LATENCY cycles.
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int          LATENCY     = 1,
  parameter string       MEM_INIT    = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  func3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int                   c_IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0]          c_WIN_BYTES = 33'(DEPTH_WORDS) << 2;
  localparam logic [MEM_LAT_W-1:0] c_CNT_INIT  = MEM_LAT_W'(LATENCY - 1);

  mem_state_t r_state;
  mem_state_t w_next;

  logic [MEM_LAT_W-1:0] r_cnt;
  logic                 r_we;
  logic [2:0]           r_func3;
  logic [31:0]          r_addr;
  logic [31:0]          r_wdata;
  logic [31:0]          r_rdata;
  logic                 r_err;

  logic [31:0] r_mem [DEPTH_WORDS];

  logic [31:0]        w_off;
  logic               w_in_win;
  logic [c_IDX_W-1:0] w_idx;
  logic [31:0]        w_raw;
  logic [3:0]         w_byte_en;
  logic [31:0]        w_wdata_sh;
  logic [31:0]        w_load_data;
  logic               w_misaligned;
  logic               w_err;
  logic               w_commit;

  // Decode on the latched address so requester changes during WAIT are ignored.
  assign w_off    = r_addr - BASE_ADDR;
  assign w_in_win = (r_addr >= BASE_ADDR) && ({1'b0, w_off} < c_WIN_BYTES);
  assign w_idx    = w_off[c_IDX_W+1:2];
  assign w_raw    = r_mem[w_idx];

  mem_lane_align u_lane_align (
    .i_func3      (r_func3),
    .i_addr_lo    (r_addr[1:0]),
    .i_wdata      (r_wdata),
    .i_raw        (w_raw),
    .o_byte_en    (w_byte_en),
    .o_wdata_sh   (w_wdata_sh),
    .o_load_data  (w_load_data),
    .o_misaligned (w_misaligned)
  );

  assign w_err    = w_misaligned || !w_in_win || func3_illegal(r_we, r_func3);
  assign w_commit = (r_state == MS_WAIT) && (r_cnt == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= MS_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      MS_IDLE: if (req) w_next = MS_WAIT;
      MS_WAIT: if (r_cnt == '0) w_next = MS_RESP;
      MS_RESP: w_next = MS_IDLE;
      default: w_next = MS_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_func3 <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if ((r_state == MS_IDLE) && req) begin
        r_we    <= we;
        r_func3 <= func3;
        r_addr  <= addr;
        r_wdata <= wdata;
        r_cnt   <= c_CNT_INIT;
      end else if ((r_state == MS_WAIT) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_commit) begin
        r_err   <= w_err;
        r_rdata <= (w_err || r_we) ? 32'h0 : w_load_data;
      end
    end
  end

  // Array is deliberately outside reset; an async reset in WAIT has already
  // moved the FSM to IDLE, so w_commit cannot fire on that edge.
  always_ff @(posedge clk) begin
    if (w_commit && r_we && !w_err) begin
      for (int i = 0; i < 4; i++) begin
        if (w_byte_en[i]) r_mem[w_idx][8*i +: 8] <= w_wdata_sh[8*i +: 8];
      end
    end
  end

  assign done  = (r_state == MS_RESP);
  assign rdata = r_rdata;
  assign err   = r_err;

endmodule
`default_nettype wire
